comparator_checker: RTL and testbench
=====================================

Name: comparator_checker

Overview:
- Synthesizable response checker for the WIDTH-bit magnitude comparator (alb/aeb/agb outputs).
- Sits on the response side of comparator bring-up:
  - A stimulus source drives a/b into the comparator.
  - This block samples the same a/b plus the three flags, computes the expected result and compares.
  - It counts vectors and mismatches and captures the first failure.
- Runs in a start/stop session, so it can be used on silicon or FPGA as well as in simulation.

Parameters:
- WIDTH, 4, operand width of a and b.
- CNT_W, 8, width of the vector counter, error counter and index registers.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin session; clears all results.
- stop  input  1  end session; drain the pipeline, then report.
- in_valid  input  1  a/b/alb/aeb/agb hold a vector to check this cycle.
- a  input  WIDTH  comparator operand A.
- b  input  WIDTH  comparator operand B.
- alb  input  1  comparator output, A<B.
- aeb  input  1  comparator output, A==B.
- agb  input  1  comparator output, A>B.
- busy  output  1  session in progress (RUN or DRAIN).
- done  output  1  results final and held.
- pass  output  1  done and err_count==0.
- err_pulse  output  1  one-cycle pulse per detected mismatch.
- vec_count  output  CNT_W  vectors checked in this session.
- err_count  output  CNT_W  mismatching vectors in this session.
- first_err_idx  output  CNT_W  vec index (0-based) of the first mismatch.
- first_err_flags  output  3  {alb,aeb,agb} seen at the first mismatch.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - All outputs go to 0, and all pipeline registers are cleared.
  - rst has priority over every other input in any state, including mid-session.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 → RUN; counters cleared at that edge.
  - RUN: in_valid vectors are accepted. stop=1 → DRAIN. start is ignored.
  - DRAIN: exactly one cycle, to finish the stage-2 compare of the last accepted vector; then → DONE.
  - DONE: done=1 and results are held. start=1 → RUN, clearing all counters, done, pass and first_err_*.
- busy=1 in RUN and DRAIN.
- Stage 1 (edge N, state RUN, in_valid=1): register a, b and the flags, and set the stage-1 valid bit.
  - in_valid is ignored in IDLE, DRAIN and DONE.
  - in_valid on the same edge that start is taken in IDLE is ignored.
  - in_valid on the same edge as stop in RUN is accepted.
- Stage 2 (edge N+1), when the stage-1 valid bit is set:
  - Expected flags: alb=(a<b), aeb=(a==b), agb=(a>b), unsigned compare over the full WIDTH.
  - Mismatch: any observed flag differs from expected. A non-one-hot observation (e.g. 000, 011, 111) is therefore always a mismatch.
  - vec_count increments.
  - On mismatch: err_count increments and err_pulse=1 for exactly that cycle.
  - On the first mismatch only: first_err_idx takes the vec_count value before the increment, and first_err_flags takes the observed flags. Both are frozen afterwards.
- Counters saturate at 2^CNT_W-1 and do not wrap. first_err_idx is frozen once set, so saturation does not affect it.
- Throughput: one vector per cycle. Back-to-back in_valid is fully supported.
- done and pass rise on the edge entering DONE.
  - pass = (err_count==0). A session with zero vectors reports pass=1.
- start and stop together in IDLE: start is taken, stop is ignored that cycle.
- start and stop together in RUN: stop is taken.

Test Plan:
- Reset then start, then 12 vectors back to back with a correct model: (0,0), (1,0), (4,4), (2,2), (12,12), (7,0), (6,6), (8,15), (5,0), (15,7), (4,1), (5,4). Then stop → vec_count=12, err_count=0, pass=1, done=1 two cycles after stop, err_pulse never asserted.
- Same sequence, but the 8th vector (8,15) reports flags 001 instead of 100 → err_count=1, first_err_idx=7, first_err_flags=3'b001, pass=0, err_pulse high for one cycle, the cycle after the edge on which the vector was sampled.
- Malformed flags: vector (3,3) with flags 000, then (3,3) with 111 → err_count=2, first_err_flags=3'b000.
- Boundary: with CNT_W=4, 20 vectors, every one wrong → vec_count=15, err_count=15 (saturated), first_err_idx=0.
- Control:
  - in_valid in IDLE and DONE is ignored (vec_count unchanged).
  - in_valid together with stop is counted.
  - start in DONE clears all results.
- rst asserted mid-RUN after 5 vectors → next cycle all outputs 0, state IDLE. A following start plus 3 vectors gives vec_count=3.

Source files
------------

// File: rtl/comparator_checker_if.sv
// Vector bus between a comparator stimulus source and its response checker:
// operands plus the three comparator flags, qualified by in_valid.
interface comparator_checker_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             alb;
    logic             aeb;
    logic             agb;

    modport master (output in_valid, a, b, alb, aeb, agb);
    modport slave  (input  in_valid, a, b, alb, aeb, agb);
endinterface

// File: rtl/comparator_checker.sv
// Response checker for a WIDTH-bit magnitude comparator: two-stage sample/compare pipeline,
// saturating vector/error counters and first-failure capture inside a start/stop session.
module comparator_checker #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    comparator_checker_if.slave   vec,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  err_pulse,
    output logic [CNT_W-1:0]      vec_count,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic [2:0]            first_err_flags
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic             s1_valid_q;
    logic             s1_load;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [2:0]       s1_flags_q;
    logic [2:0]       exp_flags;
    logic             mismatch;
    logic             clear;

    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic [2:0]       first_flags_q, first_flags_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             err_pulse_q, err_pulse_d;

    assign s1_load = (state_q == StRun) && vec.in_valid;

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    clear   = 1'b1;
                end
            end
            StRun: begin
                if (stop) state_d = StDrain;
            end
            StDrain: state_d = StDone;
            StDone: begin
                if (start) begin
                    state_d = StRun;
                    clear   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage 2: compare the vector registered on the previous edge.
    always_comb begin
        exp_flags     = {s1_a_q < s1_b_q, s1_a_q == s1_b_q, s1_a_q > s1_b_q};
        mismatch      = s1_valid_q && (s1_flags_q != exp_flags);
        vec_count_d   = vec_count_q;
        err_count_d   = err_count_q;
        first_idx_d   = first_idx_q;
        first_flags_d = first_flags_q;
        done_d        = done_q;
        pass_d        = pass_q;
        err_pulse_d   = mismatch;

        if (clear) begin
            vec_count_d   = '0;
            err_count_d   = '0;
            first_idx_d   = '0;
            first_flags_d = '0;
            done_d        = 1'b0;
            pass_d        = 1'b0;
        end else if (s1_valid_q) begin
            if (vec_count_q != CntMax) vec_count_d = vec_count_q + 1'b1;
            if (mismatch) begin
                if (err_count_q != CntMax) err_count_d = err_count_q + 1'b1;
                // err_count never wraps, so zero means no failure captured yet
                if (err_count_q == '0) begin
                    first_idx_d   = vec_count_q;
                    first_flags_d = s1_flags_q;
                end
            end
        end

        if (state_q == StDrain) begin
            done_d = 1'b1;
            pass_d = (err_count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_flags_q    <= '0;
            vec_count_q   <= '0;
            err_count_q   <= '0;
            first_idx_q   <= '0;
            first_flags_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_valid_q    <= s1_load;
            if (s1_load) begin
                s1_a_q     <= vec.a;
                s1_b_q     <= vec.b;
                s1_flags_q <= {vec.alb, vec.aeb, vec.agb};
            end
            vec_count_q   <= vec_count_d;
            err_count_q   <= err_count_d;
            first_idx_q   <= first_idx_d;
            first_flags_q <= first_flags_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_pulse_q   <= err_pulse_d;
        end
    end

    assign busy            = (state_q == StRun) || (state_q == StDrain);
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_pulse       = err_pulse_q;
    assign vec_count       = vec_count_q;
    assign err_count       = err_count_q;
    assign first_err_idx   = first_idx_q;
    assign first_err_flags = first_flags_q;
endmodule

// File: tb/tb_comparator_checker.sv
// Bench for comparator_checker: two instances (CNT_W 8 and 4) share one vector bus and are
// checked every cycle against a session-level reference model.
module tb_comparator_checker;
    localparam int WIDTH   = 4;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic clk = 1'b0;
    logic rst, start, stop;

    logic       busy8, done8, pass8, pulse8;
    logic [7:0] vc8, ec8, fi8;
    logic [2:0] ff8;
    logic       busy4, done4, pass4, pulse4;
    logic [3:0] vc4, ec4, fi4;
    logic [2:0] ff4;

    always #5 clk = ~clk;

    comparator_checker_if #(.WIDTH(WIDTH)) vec ();

    comparator_checker #(.WIDTH(WIDTH), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .vec(vec),
        .busy(busy8), .done(done8), .pass(pass8), .err_pulse(pulse8),
        .vec_count(vc8), .err_count(ec8), .first_err_idx(fi8), .first_err_flags(ff8)
    );

    comparator_checker #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .vec(vec),
        .busy(busy4), .done(done4), .pass(pass4), .err_pulse(pulse4),
        .vec_count(vc4), .err_count(ec4), .first_err_idx(fi4), .first_err_flags(ff4)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;

    // Reference model state: totals are kept unsaturated and clipped per instance.
    int         phase;
    int         n_vec, n_err, first_idx;
    logic [2:0] first_flags, pend_flags;
    bit         pend_valid, pend_bad, exp_pulse, exp_done, exp_pass;

    logic [3:0] ta [12] = '{4'd0, 4'd1, 4'd4, 4'd2, 4'd12, 4'd7, 4'd6, 4'd8, 4'd5, 4'd15, 4'd4, 4'd5};
    logic [3:0] tb [12] = '{4'd0, 4'd0, 4'd4, 4'd2, 4'd12, 4'd0, 4'd6, 4'd15, 4'd0, 4'd7, 4'd1, 4'd4};
    logic [3:0] x, y;
    logic [2:0] f;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_flags(input logic [3:0] p, input logic [3:0] q);
        int d;
        d = int'(p) - int'(q);
        if (d < 0) return 3'b100;
        if (d == 0) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic clear_results();
        n_vec = 0; n_err = 0; first_idx = 0; first_flags = '0;
        exp_done = 1'b0; exp_pass = 1'b0;
    endtask

    task automatic check_outputs();
        bit eb;
        eb = (phase == P_RUN) || (phase == P_DRAIN);
        check_eq("busy8", busy8, eb);
        check_eq("busy4", busy4, eb);
        check_eq("done8", done8, exp_done);
        check_eq("done4", done4, exp_done);
        check_eq("pass8", pass8, exp_pass);
        check_eq("pass4", pass4, exp_pass);
        check_eq("err_pulse8", pulse8, exp_pulse);
        check_eq("err_pulse4", pulse4, exp_pulse);
        check_eq("vec_count8", vc8, sat(n_vec, 255));
        check_eq("vec_count4", vc4, sat(n_vec, 15));
        check_eq("err_count8", ec8, sat(n_err, 255));
        check_eq("err_count4", ec4, sat(n_err, 15));
        check_eq("first_idx8", fi8, (n_err == 0) ? 0 : sat(first_idx, 255));
        check_eq("first_idx4", fi4, (n_err == 0) ? 0 : sat(first_idx, 15));
        check_eq("first_flags8", ff8, (n_err == 0) ? 3'b000 : first_flags);
        check_eq("first_flags4", ff4, (n_err == 0) ? 3'b000 : first_flags);
    endtask

    task automatic tick();
        bit         accept, bad;
        logic [2:0] flags;
        flags  = {vec.alb, vec.aeb, vec.agb};
        accept = (phase == P_RUN) && vec.in_valid;
        bad    = (flags != ref_flags(vec.a, vec.b));
        @(posedge clk);
        cycle++;
        if (rst) begin
            phase = P_IDLE;
            clear_results();
            pend_valid = 1'b0;
            exp_pulse  = 1'b0;
        end else begin
            exp_pulse = pend_valid && pend_bad;
            if (pend_valid) begin
                if (pend_bad) begin
                    if (n_err == 0) begin
                        first_idx   = n_vec;
                        first_flags = pend_flags;
                    end
                    n_err++;
                end
                n_vec++;
            end
            pend_valid = accept;
            pend_bad   = bad;
            pend_flags = flags;
            case (phase)
                P_IDLE:  if (start) begin phase = P_RUN; clear_results(); end
                P_RUN:   if (stop) phase = P_DRAIN;
                P_DRAIN: begin phase = P_DONE; exp_done = 1'b1; exp_pass = (n_err == 0); end
                P_DONE:  if (start) begin phase = P_RUN; clear_results(); end
                default: phase = P_IDLE;
            endcase
        end
        #1;
        check_outputs();
    endtask

    task automatic cyc(input bit s, input bit p, input bit v,
                       input logic [3:0] pa, input logic [3:0] pb, input logic [2:0] pf);
        start = s; stop = p;
        vec.in_valid = v; vec.a = pa; vec.b = pb;
        {vec.alb, vec.aeb, vec.agb} = pf;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 3'b000);
    endtask

    initial begin
        phase = P_IDLE; pend_valid = 1'b0; pend_bad = 1'b0; pend_flags = '0;
        exp_pulse = 1'b0; clear_results();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 4'd5, 3'b100);   // in_valid in IDLE: ignored

        // Session 1: clean run; stop coincides with the last vector
        cyc(1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 3'b010);   // vector on start edge: ignored
        for (int i = 0; i < 12; i++) cyc(1'b0, i == 11, 1'b1, ta[i], tb[i], ref_flags(ta[i], tb[i]));
        idle(2);
        check_eq("s1_vec_count", vc8, 12);
        check_eq("s1_pass", pass8, 1);
        cyc(1'b0, 1'b0, 1'b1, 4'd9, 4'd1, 3'b001);   // in_valid in DONE: ignored
        check_eq("s1_done_hold", vc8, 12);

        // Session 2: 8th vector reports 001 instead of 100
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'b000);
        for (int i = 0; i < 12; i++)
            cyc(1'b0, 1'b0, 1'b1, ta[i], tb[i], (i == 7) ? 3'b001 : ref_flags(ta[i], tb[i]));
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 3'b000);
        idle(2);
        check_eq("s2_err_count", ec8, 1);
        check_eq("s2_first_idx", fi8, 7);
        check_eq("s2_first_flags", ff8, 3'b001);
        check_eq("s2_pass", pass8, 0);

        // Session 3: malformed flags
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'b000);
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 3'b000);
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 3'b111);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 3'b000);
        idle(2);
        check_eq("s3_err_count", ec8, 2);
        check_eq("s3_first_flags", ff8, 3'b000);

        // Session 4: 20 wrong vectors saturate the 4-bit counters
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'b000);
        for (int i = 0; i < 20; i++) begin
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            cyc(1'b0, 1'b0, 1'b1, x, y, ~ref_flags(x, y));
        end
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 3'b000);
        idle(2);
        check_eq("s4_vec_count4", vc4, 15);
        check_eq("s4_err_count4", ec4, 15);
        check_eq("s4_first_idx4", fi4, 0);
        check_eq("s4_vec_count8", vc8, 20);

        // Session 5: random traffic; stray start ignored in RUN; start+stop in RUN takes stop
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 3'b000);
        for (int i = 0; i < 60; i++) begin
            x = 4'($urandom_range(0, 15));
            y = 4'($urandom_range(0, 15));
            f = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : ref_flags(x, y);
            cyc($urandom_range(0, 9) == 0, 1'b0, $urandom_range(0, 9) < 7, x, y, f);
        end
        cyc(1'b1, 1'b1, 1'b1, 4'd6, 4'd6, 3'b010);
        idle(2);

        // Reset mid-RUN, then start+stop in IDLE takes start
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'b000);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i), 4'd2, 3'b111);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 3'b000);
        rst = 1'b0;
        check_eq("rst_vec_count", vc8, 0);
        check_eq("rst_busy", busy8, 0);
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 3'b000);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i + 4), 4'd5, ref_flags(4'(i + 4), 4'd5));
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 3'b000);
        idle(2);
        check_eq("post_rst_vec_count", vc8, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
